// File: rtl/sample_burst_buffer.sv
// Sample buffer between the decimation filter and the SPI master: stores whole
// samples in a small RAM and hands them out one OUT_W-bit byte per done request.
module sample_burst_buffer #(
  parameter int SAMPLE_W  = 16,
  parameter int OUT_W     = 8,
  parameter int DEPTH     = 64,
  parameter int MODE      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk_out1,
  input  logic                     rst,
  input  logic [SAMPLE_W-1:0]      datafilt,
  input  logic                     filter_finished,
  input  logic                     done,
  input  logic                     flush,
  output logic [OUT_W-1:0]         data_out,
  output logic                     send,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int NB = SAMPLE_W / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_B  = BW'(NB - 1);

  typedef enum logic {S_FILL, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [BW-1:0]    byte_idx_q, byte_idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;
  logic             send_q, send_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;

  logic             rd_avail, rd_fire, rd_last;
  logic             has_room, wr_accept, wr_en;
  logic [BW-1:0]    sel;
  logic [SAMPLE_W-1:0] rd_word;
  logic [OUT_W-1:0] lane [NB];

  // Split the word at the read pointer into byte lanes, lane 0 = least significant.
  assign rd_word = mem[rd_ptr_q];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign lane[gi] = rd_word[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign sel = (MSB_FIRST != 0) ? (LAST_B - byte_idx_q) : byte_idx_q;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_out1 or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state (burst mode only; streaming never leaves FILL)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_FILL;
    end else if (MODE == 0) begin
      case (state_q)
        S_FILL:  if (count_d == DEPTH_C) state_d = S_DRAIN;
        S_DRAIN: if (count_d == '0)      state_d = S_FILL;
        default: state_d = S_FILL;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_avail  = (count_q != '0) && ((MODE == 1) || (state_q == S_DRAIN));
    rd_fire   = done && rd_avail;
    rd_last   = rd_fire && (byte_idx_q == LAST_B);
    // A read finishing its sample this cycle frees a slot for a same-cycle write.
    has_room  = (count_q != DEPTH_C) || rd_last;
    wr_accept = filter_finished && has_room && ((MODE == 1) || (state_q == S_FILL));
    wr_en     = wr_accept && !flush;
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    send_d     = 1'b0;
    overflow_d = overflow_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_idx_d = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      send_d = rd_fire;
      if (rd_fire) begin
        data_out_d = lane[sel];
        byte_idx_d = rd_last ? '0 : byte_idx_q + BW'(1);
      end
      if (rd_last) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_accept) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (filter_finished && !wr_accept) begin
        overflow_d = 1'b1;
      end
      case ({wr_accept, rd_last})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_out1 or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      send_q     <= 1'b0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      send_q     <= send_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage is never reset or flushed; only the pointers are.
  always_ff @(posedge clk_out1) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= datafilt;
    end
  end

  assign data_out = data_out_q;
  assign send     = send_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sample_burst_buffer.sv
// Directed bench: a burst-mode MSB-first buffer and a streaming LSB-first
// buffer, both DEPTH=4, driven on the falling edge and sampled on the falling edge.
module tb_sample_burst_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Burst instance (MODE 0, MSB first)
  logic        rst_b = 1'b0, ff_b = 1'b0, done_b = 1'b0, flush_b = 1'b0;
  logic [15:0] dat_b = '0;
  logic [7:0]  dout_b;
  logic        send_b, full_b, empty_b, ovf_b;
  logic [2:0]  lvl_b;

  // Streaming instance (MODE 1, LSB first)
  logic        rst_s = 1'b0, ff_s = 1'b0, done_s = 1'b0, flush_s = 1'b0;
  logic [15:0] dat_s = '0;
  logic [7:0]  dout_s;
  logic        send_s, full_s, empty_s, ovf_s;
  logic [2:0]  lvl_s;

  sample_burst_buffer #(.SAMPLE_W(16), .OUT_W(8), .DEPTH(4), .MODE(0), .MSB_FIRST(1)) u_burst (
    .clk_out1(clk), .rst(rst_b), .datafilt(dat_b), .filter_finished(ff_b),
    .done(done_b), .flush(flush_b), .data_out(dout_b), .send(send_b),
    .full(full_b), .empty(empty_b), .level(lvl_b), .overflow(ovf_b));

  sample_burst_buffer #(.SAMPLE_W(16), .OUT_W(8), .DEPTH(4), .MODE(1), .MSB_FIRST(0)) u_stream (
    .clk_out1(clk), .rst(rst_s), .datafilt(dat_s), .filter_finished(ff_s),
    .done(done_s), .flush(flush_s), .data_out(dout_s), .send(send_s),
    .full(full_s), .empty(empty_s), .level(lvl_s), .overflow(ovf_s));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic b_write(input logic [15:0] v);
    @(negedge clk); ff_b = 1'b1; dat_b = v;
    @(negedge clk); ff_b = 1'b0;
    $display("burst  write %h -> level=%0d full=%b ovf=%b", v, lvl_b, full_b, ovf_b);
  endtask

  task automatic s_write(input logic [15:0] v);
    @(negedge clk); ff_s = 1'b1; dat_s = v;
    @(negedge clk); ff_s = 1'b0;
    $display("stream write %h -> level=%0d full=%b ovf=%b", v, lvl_s, full_s, ovf_s);
  endtask

  task automatic b_byte(input string tag, input logic [7:0] exp);
    @(negedge clk); done_b = 1'b1;
    @(negedge clk); done_b = 1'b0;
    $display("burst  done -> send=%b data_out=%h", send_b, dout_b);
    check({tag, "_send"}, 32'(send_b), 32'd1);
    check({tag, "_data"}, 32'(dout_b), 32'(exp));
  endtask

  task automatic s_byte(input string tag, input logic [7:0] exp);
    @(negedge clk); done_s = 1'b1;
    @(negedge clk); done_s = 1'b0;
    $display("stream done -> send=%b data_out=%h", send_s, dout_s);
    check({tag, "_send"}, 32'(send_s), 32'd1);
    check({tag, "_data"}, 32'(dout_s), 32'(exp));
  endtask

  logic [15:0] b_samples [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  logic [7:0]  b_bytes   [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [7:0]  s_bytes   [8] = '{8'h04, 8'h03, 8'h06, 8'h05, 8'h08, 8'h07, 8'h66, 8'h55};

  initial begin
    // Reset values while reset is asserted
    repeat (2) @(negedge clk);
    check("rst_dout",  32'(dout_b),  32'h0);
    check("rst_send",  32'(send_b),  32'h0);
    check("rst_full",  32'(full_b),  32'h0);
    check("rst_empty", 32'(empty_b), 32'h1);
    check("rst_level", 32'(lvl_b),   32'h0);
    check("rst_ovf",   32'(ovf_b),   32'h0);
    check("rst_s_empty", 32'(empty_s), 32'h1);
    rst_b = 1'b1; rst_s = 1'b1;

    // Burst: fill, reject a write during drain, then drain MSB first
    foreach (b_samples[i]) b_write(b_samples[i]);
    check("fill_full",  32'(full_b), 32'h1);
    check("fill_level", 32'(lvl_b),  32'h4);
    check("fill_empty", 32'(empty_b), 32'h0);
    b_write(16'hAAAA);
    check("drop_ovf",   32'(ovf_b), 32'h1);
    check("drop_level", 32'(lvl_b), 32'h4);
    foreach (b_bytes[i]) b_byte($sformatf("drain%0d", i), b_bytes[i]);
    check("drain_empty", 32'(empty_b), 32'h1);
    check("drain_level", 32'(lvl_b),   32'h0);
    check("drain_ovf_sticky", 32'(ovf_b), 32'h1);

    @(negedge clk); flush_b = 1'b1;
    @(negedge clk); flush_b = 1'b0;
    check("flush_ovf",   32'(ovf_b),   32'h0);
    check("flush_empty", 32'(empty_b), 32'h1);
    // Back in FILL: a write is accepted without overflow
    b_write(16'h0BAD);
    check("refill_level", 32'(lvl_b), 32'h1);
    check("refill_ovf",   32'(ovf_b), 32'h0);
    @(negedge clk); flush_b = 1'b1;
    @(negedge clk); flush_b = 1'b0;
    check("flush2_level", 32'(lvl_b),  32'h0);
    check("flush2_dout",  32'(dout_b), 32'hF0);

    // done while empty is ignored
    @(negedge clk); done_b = 1'b1;
    @(negedge clk); done_b = 1'b0;
    check("idle_send", 32'(send_b), 32'h0);
    check("idle_dout", 32'(dout_b), 32'hF0);

    // Asynchronous reset mid-drain
    b_write(16'h1234); b_write(16'h1111); b_write(16'h2222); b_write(16'h3333);
    b_byte("pre_rst", 8'h12);
    @(negedge clk); rst_b = 1'b0;
    #1;
    check("arst_dout",  32'(dout_b),  32'h0);
    check("arst_full",  32'(full_b),  32'h0);
    check("arst_empty", 32'(empty_b), 32'h1);
    check("arst_level", 32'(lvl_b),   32'h0);
    check("arst_send",  32'(send_b),  32'h0);
    @(negedge clk); rst_b = 1'b1;
    b_write(16'h00FF); b_write(16'h4444); b_write(16'h5555); b_write(16'h6666);
    b_byte("post_rst0", 8'h00);
    b_byte("post_rst1", 8'hFF);

    // Streaming, LSB first; write alongside the completing read keeps level
    s_write(16'h1234);
    s_byte("s_lo", 8'h34);
    check("s_lvl1", 32'(lvl_s), 32'h1);
    @(negedge clk); ff_s = 1'b1; dat_s = 16'hBEEF; done_s = 1'b1;
    @(negedge clk); ff_s = 1'b0; done_s = 1'b0;
    check("s_hi_send", 32'(send_s), 32'h1);
    check("s_hi_data", 32'(dout_s), 32'h12);
    check("s_hi_lvl",  32'(lvl_s),  32'h1);
    s_byte("s_beef_lo", 8'hEF);
    s_byte("s_beef_hi", 8'hBE);
    check("s_empty", 32'(empty_s), 32'h1);

    // Full, then write with a sample-completing read in the same cycle
    s_write(16'h0102); s_write(16'h0304); s_write(16'h0506); s_write(16'h0708);
    check("s_full",  32'(full_s), 32'h1);
    check("s_lvl4",  32'(lvl_s),  32'h4);
    s_byte("s_0102_lo", 8'h02);
    @(negedge clk); ff_s = 1'b1; dat_s = 16'h5566; done_s = 1'b1;
    @(negedge clk); ff_s = 1'b0; done_s = 1'b0;
    check("s_swap_data", 32'(dout_s), 32'h01);
    check("s_swap_lvl",  32'(lvl_s),  32'h4);
    check("s_swap_ovf",  32'(ovf_s),  32'h0);
    check("s_swap_full", 32'(full_s), 32'h1);

    // done held high drains one byte per cycle
    @(negedge clk); done_s = 1'b1;
    foreach (s_bytes[i]) begin
      @(negedge clk);
      if (i == 7) done_s = 1'b0;
      $display("stream held done -> send=%b data_out=%h", send_s, dout_s);
      check($sformatf("s_held%0d_send", i), 32'(send_s), 32'h1);
      check($sformatf("s_held%0d_data", i), 32'(dout_s), 32'(s_bytes[i]));
    end
    @(negedge clk);
    check("s_end_send",  32'(send_s),  32'h0);
    check("s_end_level", 32'(lvl_s),   32'h0);
    check("s_end_empty", 32'(empty_s), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sample_burst_buffer.md
Name: sample_burst_buffer

Overview:
- Parametrised successor to the filter-to-SPI sample buffer.
- Stores SAMPLE_W-bit filtered samples in an internal DEPTH-entry memory and serialises each sample into OUT_W-bit bytes for the SPI transmitter, one byte per done handshake.
- Supports fill-then-drain burst mode and concurrent streaming mode, plus overflow detection, a fill-level output and a synchronous flush.
- Sits between the filter output and the SPI master, on a single clock.

Parameters:
- SAMPLE_W, 16, sample width in bits; must be an integer multiple of OUT_W.
- OUT_W, 8, output byte width in bits.
- DEPTH, 64, sample entries; power of 2, ≥2.
- MODE, 0, 0 = burst (fill to full, then drain to empty), 1 = streaming (write and drain concurrently).
- MSB_FIRST, 1, 1 = most-significant byte of each sample emitted first, 0 = least-significant first.

Ports:
- clk_out1  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- datafilt  in  SAMPLE_W  filtered sample.
- filter_finished  in  1  1-cycle strobe: datafilt valid this cycle.
- done  in  1  SPI ready / previous byte complete; request for next byte.
- flush  in  1  synchronous clear of buffer contents.
- data_out  out  OUT_W  current byte; registered, held until the next byte.
- send  out  1  1-cycle pulse: data_out updated, start SPI transfer.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- level  out  clog2(DEPTH)+1  stored sample count, including a partially sent sample.
- overflow  out  1  sticky: a sample was dropped.

Behaviour:
- Reset (rst low, asynchronous) and required reset values:
  - data_out=0, send=0, full=0, empty=1, level=0, overflow=0.
  - Write pointer, read pointer and byte index = 0; state = FILL.
- Definitions:
  - NB = SAMPLE_W/OUT_W bytes per sample.
  - count = level, registered; full and empty are registered and derived from the next count.
- Write: on filter_finished=1, write datafilt to mem[wr_ptr], then wr_ptr++ (wraps mod DEPTH) and count++. The write is accepted only if:
  - count<DEPTH, and
  - in MODE 0, state==FILL.
  - Otherwise the sample is dropped and overflow is set to 1; it clears only on reset or flush.
- Read/serialise:
  - On done=1 with a byte available, the next cycle has data_out = byte byte_idx of mem[rd_ptr] (ordering per MSB_FIRST) and send=1 for exactly one cycle.
  - Latency done→send is 1 cycle.
  - byte_idx increments per byte. After byte NB-1: byte_idx=0, rd_ptr++ (wraps), count--.
- Byte available when:
  - MODE 0: state==DRAIN and count>0.
  - MODE 1: count>0.
  - done with no byte available is ignored, not queued. done held high yields one byte per cycle.
- State machine (MODE 0):
  - FILL→DRAIN in the cycle after count reaches DEPTH.
  - DRAIN→FILL in the cycle after the last byte of the last sample is emitted (count becomes 0).
  - MODE 1 remains in FILL/stream permanently; state is unused.
- Simultaneous events:
  - Accepted write and last-byte read in the same cycle: count unchanged, both pointers advance.
  - Write when full with a same-cycle completing read (MODE 1): the write is accepted, because full is evaluated on the registered count before the read and the completing read frees the slot. The result is no overflow, count unchanged.
- Flush:
  - Sync, priority over all other operations.
  - Clears pointers, byte_idx, count, overflow and send; state = FILL; data_out holds its value.
  - Memory contents are not cleared.
- Asynchronous reset mid-drain abandons the partial sample; there is no resume.
- Memory is inferred RAM or registers, with a combinational read of mem[rd_ptr]; no FIFO IP.

Test Plan (SAMPLE_W=16, OUT_W=8, DEPTH=4 unless stated):
- MODE 0, write 0x1234,0x5678,0x9ABC,0xDEF0, then pulse done 8 times → full=1 after the 4th write. Bytes out 12,34,56,78,9A,BC,DE,F0 each with a 1-cycle send 1 cycle after done; empty=1 and state FILL after the last byte.
- MODE 0, during DRAIN strobe filter_finished with 0xAAAA → sample dropped, overflow=1 and stays 1, level unchanged; flush → overflow=0, level=0, empty=1.
- MODE 1, MSB_FIRST=0, write 0x1234, done, done → data_out 0x34 then 0x12. A write in the same cycle as the 2nd done keeps level=1.
- MODE 1, fill to level=4, then in one cycle write 0x5555 and issue done completing the last byte of a sample → no overflow, level=4, wr_ptr and rd_ptr both wrap to 0 correctly.
- done with empty=1 → send stays 0, data_out unchanged.
- rst low mid-drain after one byte of 0x1234 → all outputs at reset values immediately. Then write 0x00FF, done → emits 0x00 first.
